// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit with the architectural HI/LO registers.
//   It sits in the E stage beside the ALU and runs mult/multu/div/divu/mthi/
//   mtlo from already-forwarded operands.
//
//   The 64-bit result is computed in the accept cycle and held in shadow
//   registers. It is copied to HI/LO only after the configured latency, so
//   software sees the timing of an iterative unit.
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  : busy cycles for div/divu   (>= 1)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   md_op  in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//               7 reserved (behaves as none)
//   src_a  in   [31:0] rs operand
//   src_b  in   [31:0] rt operand
//   rd_hi  in   selects HI (1) or LO (0) onto md_out
//   start  out  combinational, md_op is a multiply/divide this cycle
//   busy   out  registered, an operation is in flight
//   md_out out  [31:0] HI or LO as selected by rd_hi (committed value)
//   hi     out  [31:0] HI register
//   lo     out  [31:0] LO register
//
// Handshake: md_op is a one-cycle request and carries no ready signal.
//   A multiply/divide is taken only when busy is low. While busy is high, all
//   md_op values are dropped, so upstream hazard logic must stall on
//   start|busy.
// -----------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        rd_hi,
   output logic        start,
   output logic        busy,
   output logic [31:0] md_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_sh_hi;
   logic [31:0]   r_sh_lo;
   logic          r_sh_wr;   // low for divide-by-zero: commit leaves HI/LO alone

   logic          w_start;
   logic          w_is_div;
   logic          w_div_zero;
   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [31:0]   w_mag_a;
   logic [31:0]   w_mag_b;
   logic [31:0]   w_den_s;
   logic [31:0]   w_den_u;
   logic [31:0]   w_mag_q;
   logic [31:0]   w_mag_r;
   logic [31:0]   w_sq;
   logic [31:0]   w_sr;
   logic [31:0]   w_uq;
   logic [31:0]   w_ur;
   logic [31:0]   w_res_hi;
   logic [31:0]   w_res_lo;
   logic [CW-1:0] w_load_n;

   assign w_start    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign w_is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign w_div_zero = (src_b == 32'd0);

   // The low 64 bits of a product of sign-extended operands give the signed result.
   assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
   assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Signed divide is done on magnitudes so that 0x80000000 / -1 is well
   // defined. The magnitude 0x80000000 negates back to 0x80000000.
   assign w_mag_a = src_a[31] ? (~src_a + 32'd1) : src_a;
   assign w_mag_b = src_b[31] ? (~src_b + 32'd1) : src_b;
   // The zero divisor is replaced so the dividers never produce X.
   // The result is discarded anyway.
   assign w_den_s = w_div_zero ? 32'd1 : w_mag_b;
   assign w_den_u = w_div_zero ? 32'd1 : src_b;
   assign w_mag_q = w_mag_a / w_den_s;
   assign w_mag_r = w_mag_a % w_den_s;
   assign w_sq    = (src_a[31] ^ src_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
   assign w_sr    = src_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
   assign w_uq    = src_a / w_den_u;
   assign w_ur    = src_a % w_den_u;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      w_load_n = MULT_N;
      case (md_op)
         OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
         OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
         OP_DIV:   begin w_res_hi = w_sr; w_res_lo = w_sq; w_load_n = DIV_N; end
         OP_DIVU:  begin w_res_hi = w_ur; w_res_lo = w_uq; w_load_n = DIV_N; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_sh_hi <= 32'd0;
         r_sh_lo <= 32'd0;
         r_sh_wr <= 1'b0;
      end else if (r_busy) begin
         // All md_op values are dropped here. The committing op owns HI/LO.
         if (r_cnt == CW'(1)) begin
            if (r_sh_wr) begin
               r_hi <= r_sh_hi;
               r_lo <= r_sh_lo;
            end
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end else if (w_start) begin
         r_sh_hi <= w_res_hi;
         r_sh_lo <= w_res_lo;
         r_sh_wr <= !(w_is_div && w_div_zero);
         r_cnt   <= w_load_n;
         r_busy  <= 1'b1;
      end else if (md_op == OP_MTHI) begin
         r_hi <= src_a;
      end else if (md_op == OP_MTLO) begin
         r_lo <= src_a;
      end
   end

   assign start  = w_start;
   assign busy   = r_busy;
   assign hi     = r_hi;
   assign lo     = r_lo;
   assign md_out = rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_hi  (rd_hi),
    .start  (start),
    .busy   (busy),
    .md_out (md_out),
    .hi     (hi),
    .lo     (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    src_a = a;
    src_b = b;
    #1;
    check("start_on_issue", {31'd0, start}, 32'd1);
    check("idle_before_accept", {31'd0, busy}, 32'd0);
    tick();
    md_op = 3'd0;
  endtask

  // Called right after the accept edge: busy must hold for n samples and
  // then drop.
  task automatic wait_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, {31'd0, busy}, 32'd1);
      tick();
    end
    check({tag, "_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    md_op = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    rd_hi = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // md_op 7 is reserved and must behave as none.
    md_op = 3'd7;
    src_a = 32'h55AA55AA;
    #1;
    check("rsvd_start", {31'd0, start}, 32'd0);
    tick();
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_lo", lo, 32'd0);
    md_op = 3'd0;

    // T1: mult -2 * 3
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    check("t1_hi_pre", hi, 32'd0);
    wait_busy("t1_busy", 5);
    check("t1_hi", hi, 32'hFFFFFFFF);
    check("t1_lo", lo, 32'hFFFFFFFA);

    // T2: multu max * max, then the md_out select
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_busy("t2_busy", 5);
    check("t2_hi", hi, 32'hFFFFFFFE);
    check("t2_lo", lo, 32'h00000001);
    rd_hi = 1'b1;
    #1;
    check("t2_mdout_hi", md_out, 32'hFFFFFFFE);
    rd_hi = 1'b0;
    #1;
    check("t2_mdout_lo", md_out, 32'h00000001);
    tick();

    // T3: signed, unsigned and overflow divides
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_busy("t3_div_busy", 10);
    check("t3_div_lo", lo, 32'hFFFFFFFD);
    check("t3_div_hi", hi, 32'hFFFFFFFF);
    issue(3'd4, 32'd7, 32'd2);
    wait_busy("t3_divu_busy", 10);
    check("t3_divu_lo", lo, 32'd3);
    check("t3_divu_hi", hi, 32'd1);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy("t3_ovf_busy", 10);
    check("t3_ovf_lo", lo, 32'h80000000);
    check("t3_ovf_hi", hi, 32'd0);

    // T4: mthi/mtlo on back-to-back cycles, then divide by zero
    md_op = 3'd5;
    src_a = 32'h12345678;
    #1;
    check("t4_mthi_start", {31'd0, start}, 32'd0);
    tick();
    check("t4_mthi_hi", hi, 32'h12345678);
    check("t4_mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd6;
    src_a = 32'h9ABCDEF0;
    tick();
    md_op = 3'd0;
    check("t4_mtlo_lo", lo, 32'h9ABCDEF0);
    check("t4_mtlo_busy", {31'd0, busy}, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_busy("t4_dz_busy", 10);
    check("t4_dz_hi", hi, 32'h12345678);
    check("t4_dz_lo", lo, 32'h9ABCDEF0);
    issue(3'd4, 32'd9, 32'd0);
    wait_busy("t4_dzu_busy", 10);
    check("t4_dzu_hi", hi, 32'h12345678);
    check("t4_dzu_lo", lo, 32'h9ABCDEF0);

    // T5: div and mthi arriving while a mult is running are dropped
    issue(3'd1, 32'd3, 32'd4);          // accept edge k
    tick();                             // k+1
    md_op = 3'd3;
    src_a = 32'd100;
    src_b = 32'd7;
    #1;
    check("t5_start_busy", {31'd0, start}, 32'd1);
    tick();                             // k+2
    check("t5_busy_k2", {31'd0, busy}, 32'd1);
    md_op = 3'd5;
    src_a = 32'hDEADBEEF;
    tick();                             // k+3
    md_op = 3'd0;
    check("t5_mthi_ignored", hi, 32'h12345678);
    check("t5_busy_k3", {31'd0, busy}, 32'd1);
    tick();                             // k+4
    check("t5_busy_k4", {31'd0, busy}, 32'd1);
    check("t5_lo_k4", lo, 32'h9ABCDEF0);
    tick();                             // k+5
    check("t5_busy_drop", {31'd0, busy}, 32'd0);
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd12);
    tick();
    check("t5_no_restart", {31'd0, busy}, 32'd0);

    // T6: asynchronous reset in the middle of a div
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_hi", hi, 32'd0);
    check("t6_rst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_idle_after", {31'd0, busy}, 32'd0);
    issue(3'd1, 32'h00010000, 32'h00010000);
    wait_busy("t6_mult_busy", 5);
    check("t6_hi", hi, 32'd1);
    check("t6_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
